pio_in_capture: RTL and testbench

Parametrised Avalon-MM slave input port for the Nios II system; next generation of the fixed 8-bit switch input.
- Synchronises a WIDTH-bit asynchronous input bus.
- Exposes the synchronised value, per-bit edge capture and an interrupt mask as memory-mapped registers.
- Drives an interrupt line to the processor.
- One instance per input bank (switches, keys).

---
 rtl/pio_in_capture.sv | 94 +++++++++
 tb/tb_pio_in_capture.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_in_capture.sv
// Avalon-MM input port: synchronises an asynchronous input bus, captures per-bit edges
// and raises an interrupt from the captured edges or the input level.
module pio_in_capture #(
   parameter int unsigned     WIDTH       = 8,
   parameter int unsigned     SYNC_STAGES = 2,
   parameter int unsigned     EDGE_TYPE   = 0,
   parameter int unsigned     IRQ_MODE    = 0,
   parameter logic [WIDTH-1:0] RESET_MASK = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] data_sync;
   logic [WIDTH-1:0] data_prev_q;
   logic [WIDTH-1:0] rise, fall, edge_bits;
   logic [WIDTH-1:0] wr_bits;
   logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
   logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
   logic [31:0]      readdata_d;
   logic             wr_en;
   logic             unused_wdata;

   assign data_sync = sync_q[SYNC_STAGES-1];
   assign wr_en     = chipselect & ~write_n;
   assign wr_bits   = writedata[WIDTH-1:0];
   // Bits above WIDTH are deliberately ignored.
   assign unused_wdata = ^writedata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= in_port;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   always_comb begin
      rise = data_sync & ~data_prev_q;
      fall = ~data_sync & data_prev_q;
      if (EDGE_TYPE == 0)      edge_bits = rise;
      else if (EDGE_TYPE == 1) edge_bits = fall;
      else                     edge_bits = rise | fall;
   end

   always_comb begin
      // A new edge overrides a write-1-clear landing on the same bit.
      edge_capture_d = edge_bits |
                       (edge_capture_q & ~((wr_en && address == 2'd3) ? wr_bits : '0));
      irq_mask_d     = (wr_en && address == 2'd2) ? wr_bits : irq_mask_q;
   end

   always_comb begin
      readdata_d = '0;
      case (address)
         2'd0:    readdata_d[WIDTH-1:0] = data_sync;
         2'd2:    readdata_d[WIDTH-1:0] = irq_mask_q;
         2'd3:    readdata_d[WIDTH-1:0] = edge_capture_q;
         default: readdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_prev_q    <= '0;
         edge_capture_q <= '0;
         irq_mask_q     <= RESET_MASK;
         readdata       <= '0;
      end else begin
         data_prev_q    <= data_sync;
         edge_capture_q <= edge_capture_d;
         irq_mask_q     <= irq_mask_d;
         readdata       <= readdata_d;
      end
   end

   generate
      if (IRQ_MODE == 0) begin : g_irq_edge
         assign irq = |(edge_capture_q & irq_mask_q);
      end else begin : g_irq_level
         assign irq = |(data_sync & irq_mask_q);
      end
   endgenerate

endmodule

// File: tb/tb_pio_in_capture.sv
// Directed bench for pio_in_capture: an 8-bit rising-edge instance and a 32-bit
// any-edge, level-irq instance sharing one clock.
module tb_pio_in_capture;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // 8-bit, rising edge, irq from edge capture, reset mask 0x05
   logic        a_reset;
   logic [1:0]  a_address;
   logic        a_cs;
   logic        a_wn;
   logic [31:0] a_wd;
   logic [7:0]  a_in;
   logic [31:0] a_readdata;
   logic        a_irq;

   // 32-bit, any edge, irq from input level
   logic        b_reset;
   logic [1:0]  b_address;
   logic        b_cs;
   logic        b_wn;
   logic [31:0] b_wd;
   logic [31:0] b_in;
   logic [31:0] b_readdata;
   logic        b_irq;

   pio_in_capture #(
      .WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(0), .RESET_MASK(8'h05)
   ) u_a (
      .clk(clk), .reset(a_reset), .address(a_address), .chipselect(a_cs), .write_n(a_wn),
      .writedata(a_wd), .in_port(a_in), .readdata(a_readdata), .irq(a_irq)
   );

   pio_in_capture #(
      .WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(2), .IRQ_MODE(1), .RESET_MASK(32'h0)
   ) u_b (
      .clk(clk), .reset(b_reset), .address(b_address), .chipselect(b_cs), .write_n(b_wn),
      .writedata(b_wd), .in_port(b_in), .readdata(b_readdata), .irq(b_irq)
   );

   // All tasks start and end 1 time unit after a rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic a_write(input logic [1:0] addr, input logic [31:0] data);
      a_address = addr; a_cs = 1'b1; a_wn = 1'b0; a_wd = data;
      step();
      a_cs = 1'b0; a_wn = 1'b1; a_wd = '0;
   endtask

   task automatic b_write(input logic [1:0] addr, input logic [31:0] data);
      b_address = addr; b_cs = 1'b1; b_wn = 1'b0; b_wd = data;
      step();
      b_cs = 1'b0; b_wn = 1'b1; b_wd = '0;
   endtask

   task automatic test_reset();
      logic [31:0] exp;
      a_reset = 1'b1; b_reset = 1'b1;
      a_address = 2'd0; a_cs = 1'b0; a_wn = 1'b1; a_wd = '0; a_in = '0;
      b_address = 2'd0; b_cs = 1'b0; b_wn = 1'b1; b_wd = '0; b_in = '0;
      repeat (2) @(posedge clk);
      #1;
      a_reset = 1'b0; b_reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a_address = 2'(i);
         step();
         exp = (i == 2) ? 32'h0000_0005 : 32'h0;
         total++;
         if (a_readdata !== exp) begin
            bad++;
            $display("FAIL reset_read addr=%0d got=%h want=%h", i, a_readdata, exp);
         end
         total++;
         if (a_irq !== 1'b0) begin
            bad++;
            $display("FAIL reset_irq addr=%0d got=%b want=0", i, a_irq);
         end
      end
      total++;
      if (b_readdata !== 32'h0 || b_irq !== 1'b0) begin
         bad++;
         $display("FAIL reset_b got rd=%h irq=%b want rd=0 irq=0", b_readdata, b_irq);
      end
   endtask

   task automatic test_data_sync();
      logic [31:0] exp;
      a_address = 2'd0;
      a_in = 8'hA5;
      for (int k = 1; k <= 5; k++) begin
         step();
         exp = (k >= 3) ? 32'h0000_00A5 : 32'h0;
         total++;
         if (a_readdata !== exp) begin
            bad++;
            $display("FAIL data_latency cycle=%0d got=%h want=%h", k, a_readdata, exp);
         end
      end
      // Rising bits 0 and 2 hit the reset mask 0x05.
      total++;
      if (a_irq !== 1'b1) begin
         bad++;
         $display("FAIL reset_mask_irq got=%b want=1", a_irq);
      end
      a_in = 8'h00;
      repeat (3) step();
      a_write(2'd3, 32'hFF);
      step();
      total++;
      if (a_readdata !== 32'h0 || a_irq !== 1'b0) begin
         bad++;
         $display("FAIL clear_all got rd=%h irq=%b want rd=0 irq=0", a_readdata, a_irq);
      end
   endtask

   task automatic test_edge_capture();
      a_write(2'd2, 32'h0);
      a_in = 8'h08;
      repeat (5) step();
      a_in = 8'h00;
      repeat (5) step();
      a_address = 2'd3;
      step();
      total++;
      if (a_readdata !== 32'h0000_0008) begin
         bad++;
         $display("FAIL edge_bit3 got=%h want=00000008", a_readdata);
      end
      step();
      total++;
      if (a_readdata !== 32'h0000_0008) begin
         bad++;
         $display("FAIL edge_sticky got=%h want=00000008", a_readdata);
      end
      total++;
      if (a_irq !== 1'b0) begin
         bad++;
         $display("FAIL edge_masked_irq got=%b want=0", a_irq);
      end
      a_write(2'd3, 32'h8);
      step();
      total++;
      if (a_readdata !== 32'h0) begin
         bad++;
         $display("FAIL edge_w1c got=%h want=0", a_readdata);
      end
   endtask

   task automatic test_irq();
      a_write(2'd2, 32'h08);
      a_in = 8'h08;
      step();
      step();
      total++;
      if (a_irq !== 1'b0) begin
         bad++;
         $display("FAIL irq_early got=%b want=0", a_irq);
      end
      step();
      total++;
      if (a_irq !== 1'b1) begin
         bad++;
         $display("FAIL irq_rise got=%b want=1", a_irq);
      end
      a_write(2'd2, 32'h0);
      total++;
      if (a_irq !== 1'b0) begin
         bad++;
         $display("FAIL irq_unmask got=%b want=0", a_irq);
      end
      a_address = 2'd3;
      step();
      total++;
      if (a_readdata !== 32'h0000_0008) begin
         bad++;
         $display("FAIL irq_capture_kept got=%h want=00000008", a_readdata);
      end
      a_in = 8'h00;
      repeat (3) step();
      a_write(2'd3, 32'hFF);
   endtask

   task automatic test_collision();
      a_in = 8'h02;
      repeat (4) step();
      a_address = 2'd3;
      step();
      total++;
      if (a_readdata !== 32'h0000_0002) begin
         bad++;
         $display("FAIL coll_setup got=%h want=00000002", a_readdata);
      end
      a_in = 8'h03;
      step();
      step();
      // Rise term on bit0 is live for the next edge, where the clear lands.
      a_write(2'd3, 32'h03);
      step();
      total++;
      if (a_readdata !== 32'h0000_0001) begin
         bad++;
         $display("FAIL coll_set_wins got=%h want=00000001", a_readdata);
      end
      a_in = 8'h00;
      repeat (3) step();
      a_write(2'd3, 32'hFF);
   endtask

   task automatic test_level_irq();
      b_write(2'd2, 32'h8000_0000);
      b_in = 32'h8000_0000;
      step();
      total++;
      if (b_irq !== 1'b0) begin
         bad++;
         $display("FAIL lvl_irq_early got=%b want=0", b_irq);
      end
      step();
      total++;
      if (b_irq !== 1'b1) begin
         bad++;
         $display("FAIL lvl_irq_rise got=%b want=1", b_irq);
      end
      b_address = 2'd3;
      step();
      step();
      total++;
      if (b_readdata !== 32'h8000_0000) begin
         bad++;
         $display("FAIL any_rise got=%h want=80000000", b_readdata);
      end
      b_write(2'd3, 32'h8000_0000);
      step();
      total++;
      if (b_readdata !== 32'h0) begin
         bad++;
         $display("FAIL b_w1c got=%h want=0", b_readdata);
      end
      b_in = 32'h0;
      repeat (4) step();
      total++;
      if (b_readdata !== 32'h8000_0000) begin
         bad++;
         $display("FAIL any_fall got=%h want=80000000", b_readdata);
      end
      total++;
      if (b_irq !== 1'b0) begin
         bad++;
         $display("FAIL lvl_irq_fall got=%b want=0", b_irq);
      end
   endtask

   task automatic test_reset_midstream();
      b_address = 2'd0;
      b_in = 32'h8000_0000;
      repeat (4) step();
      total++;
      if (b_irq !== 1'b1 || b_readdata !== 32'h8000_0000) begin
         bad++;
         $display("FAIL mid_pre got rd=%h irq=%b want rd=80000000 irq=1", b_readdata, b_irq);
      end
      #2;
      b_reset = 1'b1;
      #1;
      total++;
      if (b_irq !== 1'b0 || b_readdata !== 32'h0) begin
         bad++;
         $display("FAIL mid_async got rd=%h irq=%b want rd=0 irq=0", b_readdata, b_irq);
      end
      step();
      b_reset = 1'b0;
      b_address = 2'd2;
      step();
      total++;
      if (b_readdata !== 32'h0) begin
         bad++;
         $display("FAIL mid_mask_lost got=%h want=0", b_readdata);
      end
      b_address = 2'd3;
      step();
      total++;
      if (b_irq !== 1'b0) begin
         bad++;
         $display("FAIL mid_irq_masked got=%b want=0", b_irq);
      end
      step();
      total++;
      if (b_readdata !== 32'h0) begin
         bad++;
         $display("FAIL mid_edge_early got=%h want=0", b_readdata);
      end
      step();
      total++;
      if (b_readdata !== 32'h8000_0000) begin
         bad++;
         $display("FAIL mid_first_edge got=%h want=80000000", b_readdata);
      end
   endtask

   initial begin
      test_reset();
      test_data_sync();
      test_edge_capture();
      test_irq();
      test_collision();
      test_level_irq();
      test_reset_midstream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
